// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mac_pkg
// Brief   : Shared widths and types for the MAC result collector.
// Revision: 1.0 - initial release
// ============================================================================
package mac_pkg;

    localparam int PSUM_WIDTH  = 34;
    localparam int MAC_LATENCY = 3;
    localparam int ACC_WIDTH   = 40;
    localparam int OUT_WIDTH   = 16;

    typedef struct packed {
        logic signed [OUT_WIDTH-1:0] data;
        logic                        sat;
    } res_entry_t;

    typedef struct packed {
        logic valid;
        logic last;
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/mac_result_collector_if.sv
`default_nettype none
// ============================================================================
// Module  : mac_result_collector_if
// Brief   : Issue-credit and result valid/ready bundle of the result collector.
// Revision: 1.0 - initial release
// ============================================================================
interface mac_result_collector_if #(
    parameter int PSUM_WIDTH = mac_pkg::PSUM_WIDTH,
    parameter int OUT_WIDTH  = mac_pkg::OUT_WIDTH
) ();

    logic                         issue_valid_in;
    logic                         issue_last_in;
    logic                         issue_ready_out;
    logic [PSUM_WIDTH-1:0]        psum_in;
    logic [5:0]                   cfg_shift_in;
    logic                         res_valid_out;
    logic                         res_ready_in;
    logic signed [OUT_WIDTH-1:0]  res_data_out;
    logic                         res_sat_out;

    modport master (
        output issue_valid_in, issue_last_in, psum_in, cfg_shift_in, res_ready_in,
        input  issue_ready_out, res_valid_out, res_data_out, res_sat_out
    );

    modport slave (
        input  issue_valid_in, issue_last_in, psum_in, cfg_shift_in, res_ready_in,
        output issue_ready_out, res_valid_out, res_data_out, res_sat_out
    );

endinterface
`default_nettype wire

// File: rtl/mac_result_fifo.sv
`default_nettype none
// ============================================================================
// Module  : mac_result_fifo
// Brief   : Synchronous first-word-fall-through FIFO of requantised results.
// Revision: 1.0 - initial release
// ============================================================================
module mac_result_fifo
    import mac_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst_in,
    input  wire logic                     i_push,
    input  wire res_entry_t               i_push_data,
    input  wire logic                     i_pop,
    output res_entry_t                    o_head,
    output logic [$clog2(DEPTH):0]        o_count
);

    localparam int c_addr_w = $clog2(DEPTH);

    res_entry_t            r_mem [DEPTH];
    logic [c_addr_w-1:0]   r_wr_ptr;
    logic [c_addr_w-1:0]   r_rd_ptr;
    logic [c_addr_w:0]     r_count;
    logic                  w_pop;

    // Popping an empty FIFO is silently ignored.
    assign w_pop = i_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/mac_result_collector.sv
`default_nettype none
// ============================================================================
// Module  : mac_result_collector
// Brief   : Matures MAC partial sums, accumulates groups, requantises and
//           buffers results while issuing credit to the operand feeder.
// Revision: 1.0 - initial release
// ============================================================================
module mac_result_collector #(
    parameter int PSUM_WIDTH  = mac_pkg::PSUM_WIDTH,
    parameter int MAC_LATENCY = mac_pkg::MAC_LATENCY,
    parameter int ACC_WIDTH   = mac_pkg::ACC_WIDTH,
    parameter int OUT_WIDTH   = mac_pkg::OUT_WIDTH,
    parameter int FIFO_DEPTH  = 4
) (
    input  wire logic               clk,
    input  wire logic               rst_in,
    mac_result_collector_if.slave   bus,
    output logic                    busy_out
);
    import mac_pkg::*;

    localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;
    localparam logic signed [ACC_WIDTH:0] c_one = (ACC_WIDTH+1)'(1);
    localparam logic signed [ACC_WIDTH:0] c_max = (c_one <<< (OUT_WIDTH-1)) - c_one;
    localparam logic signed [ACC_WIDTH:0] c_min = ~c_max;

    tag_t                        r_tag [MAC_LATENCY];
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic                        r_acc_nonempty;

    tag_t                        w_mature;
    logic                        w_ready;
    logic                        w_accept;
    logic                        w_push;
    logic [7:0]                  w_inflight_last;
    logic [7:0]                  w_reserved;
    logic                        w_any_valid;
    logic [c_cnt_w-1:0]          w_count;
    logic signed [ACC_WIDTH-1:0] w_sum;
    logic signed [ACC_WIDTH:0]   w_ext;
    logic signed [ACC_WIDTH:0]   w_round;
    logic signed [ACC_WIDTH:0]   w_shifted;
    res_entry_t                  w_entry;
    res_entry_t                  w_head;

    assign w_mature = r_tag[MAC_LATENCY-1];
    assign w_accept = bus.issue_valid_in & w_ready;
    assign w_push   = w_mature.valid & w_mature.last;

    // Every last tag in flight already owns a FIFO slot, so a push never finds it full.
    always_comb begin
        w_inflight_last = '0;
        w_any_valid     = 1'b0;
        for (int i = 0; i < MAC_LATENCY; i++) begin
            w_inflight_last = w_inflight_last + {7'd0, r_tag[i].valid & r_tag[i].last};
            w_any_valid     = w_any_valid | r_tag[i].valid;
        end
    end

    assign w_reserved = 8'(w_count) + w_inflight_last;
    assign w_ready    = (w_reserved < 8'(FIFO_DEPTH));

    // Round half up, then arithmetic shift, one bit wider than the accumulator.
    assign w_sum     = r_acc + {{(ACC_WIDTH-PSUM_WIDTH){bus.psum_in[PSUM_WIDTH-1]}}, bus.psum_in};
    assign w_ext     = {w_sum[ACC_WIDTH-1], w_sum};
    assign w_round   = (bus.cfg_shift_in != 6'd0) ? (c_one << (bus.cfg_shift_in - 6'd1)) : '0;
    assign w_shifted = (w_ext + w_round) >>> bus.cfg_shift_in;

    always_comb begin
        w_entry = '0;
        if (w_shifted > c_max) begin
            w_entry.data = c_max[OUT_WIDTH-1:0];
            w_entry.sat  = 1'b1;
        end else if (w_shifted < c_min) begin
            w_entry.data = c_min[OUT_WIDTH-1:0];
            w_entry.sat  = 1'b1;
        end else begin
            w_entry.data = w_shifted[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            for (int i = 0; i < MAC_LATENCY; i++) begin
                r_tag[i] <= '0;
            end
            r_acc          <= '0;
            r_acc_nonempty <= 1'b0;
        end else begin
            r_tag[0] <= '{valid: w_accept, last: w_accept & bus.issue_last_in};
            for (int i = 1; i < MAC_LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            if (w_mature.valid) begin
                if (w_mature.last) begin
                    r_acc          <= '0;
                    r_acc_nonempty <= 1'b0;
                end else begin
                    r_acc          <= w_sum;
                    r_acc_nonempty <= 1'b1;
                end
            end
        end
    end

    // The FIFO entry type is sized by the package OUT_WIDTH.
    mac_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_in      (rst_in),
        .i_push      (w_push),
        .i_push_data (w_entry),
        .i_pop       (bus.res_ready_in),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign bus.issue_ready_out = w_ready;
    assign bus.res_valid_out   = (w_count != '0);
    assign bus.res_data_out    = w_head.data;
    assign bus.res_sat_out     = w_head.sat;
    assign busy_out            = w_any_valid | r_acc_nonempty;

endmodule
`default_nettype wire

// File: tb/tb_mac_result_collector.sv
`default_nettype none
// ============================================================================
// Module  : tb_mac_result_collector
// Brief   : Directed and random stimulus against a group-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mac_result_collector;

    logic clk = 1'b0;
    logic rst_in;
    logic busy_out;

    always #5 clk = ~clk;

    mac_result_collector_if #(.PSUM_WIDTH(34), .OUT_WIDTH(16)) bus ();

    mac_result_collector #(
        .PSUM_WIDTH  (34),
        .MAC_LATENCY (3),
        .ACC_WIDTH   (40),
        .OUT_WIDTH   (16),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk      (clk),
        .rst_in   (rst_in),
        .bus      (bus.slave),
        .busy_out (busy_out)
    );

    // MAC emulation: each accepted issue carries its psum/shift until it matures.
    typedef struct {
        bit                 valid;
        bit                 last;
        logic signed [33:0] psum;
        logic [5:0]         sh;
    } iss_t;

    iss_t        pipe [3];
    longint      acc_m;
    bit          grp_open;
    int          n_reserved;
    logic [16:0] expq [$];
    int          n_tests;
    int          n_fail;

    function automatic longint wrap40(input longint x);
        return (x <<< 24) >>> 24;
    endfunction

    // Returns {sat, data} for a closed group sum.
    function automatic logic [16:0] requant(input longint sum, input int sh);
        longint r;
        r = sum + ((sh > 0) ? (longint'(1) <<< (sh - 1)) : longint'(0));
        r = r >>> sh;
        if (r > 32767)  return {1'b1, 16'h7fff};
        if (r < -32768) return {1'b1, 16'h8000};
        return {1'b0, r[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, '0, '0};
        acc_m      = 0;
        grp_open   = 0;
        n_reserved = 0;
        expq.delete();
    endtask

    task automatic step(input bit v, input bit last, input logic signed [33:0] ps,
                        input logic [5:0] sh, input bit rdy);
        bit          exp_ready;
        bit          any_v;
        logic [16:0] head;
        bus.issue_valid_in = v;
        bus.issue_last_in  = last;
        bus.res_ready_in   = rdy;
        if (pipe[2].valid) begin
            bus.psum_in      = pipe[2].psum;
            bus.cfg_shift_in = pipe[2].sh;
        end else begin
            bus.psum_in      = 34'({$urandom(), $urandom()});
            bus.cfg_shift_in = 6'($urandom_range(0, 63));
        end
        @(negedge clk);
        exp_ready = (n_reserved < 4);
        any_v     = pipe[0].valid | pipe[1].valid | pipe[2].valid;
        head      = (expq.size() != 0) ? expq[0] : 17'd0;
        chk("issue_ready", 32'(bus.issue_ready_out), 32'(exp_ready));
        chk("res_valid",   32'(bus.res_valid_out),   32'(expq.size() != 0));
        chk("res_data",    32'($unsigned(bus.res_data_out)), 32'(head[15:0]));
        chk("res_sat",     32'(bus.res_sat_out),     32'(head[16]));
        chk("busy",        32'(busy_out),            32'(any_v | grp_open));
        if (expq.size() != 0 && rdy) begin
            void'(expq.pop_front());
            n_reserved--;
        end
        if (pipe[2].valid) begin
            acc_m = wrap40(acc_m + longint'(pipe[2].psum));
            if (pipe[2].last) begin
                expq.push_back(requant(acc_m, int'(pipe[2].sh)));
                acc_m    = 0;
                grp_open = 0;
            end else begin
                grp_open = 1;
            end
        end
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = '{v & exp_ready, last, ps, sh};
        if (v && exp_ready && last) n_reserved++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, '0, '0, rdy);
    endtask

    task automatic do_reset();
        bus.issue_valid_in = 1'b0;
        rst_in = 1'b1;
        @(posedge clk);
        #1;
        rst_in = 1'b0;
        clear_model();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        bus.issue_valid_in = 1'b0;
        bus.issue_last_in  = 1'b0;
        bus.res_ready_in   = 1'b0;
        bus.psum_in        = '0;
        bus.cfg_shift_in   = '0;
        rst_in = 1'b1;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        rst_in = 1'b0;

        // Single-issue group with rounding shift.
        step(1, 1, 34'sh1234, 6'd4, 1);
        repeat (6) idle(1);

        // Four-issue group.
        step(1, 0, 34'sd100, 6'd0, 1);
        step(1, 0, -34'sd30, 6'd0, 1);
        step(1, 0, 34'sd7,   6'd0, 1);
        step(1, 1, 34'sd3,   6'd0, 1);
        repeat (6) idle(1);

        // Saturation both ways and round half up.
        step(1, 1, 34'sh0_4000_0000, 6'd0, 1);
        step(1, 1, 34'sh3_C000_0000, 6'd0, 1);
        step(1, 1, 34'sd3,           6'd1, 1);
        repeat (6) idle(1);

        // Backpressure: credit runs out after four buffered results.
        repeat (6) step(1, 1, 34'($urandom_range(0, 5000)), 6'd0, 0);
        repeat (4) idle(0);
        repeat (8) idle(1);

        // Near-full FIFO with concurrent push and pop across pointer wrap.
        repeat (3) step(1, 1, 34'($urandom_range(0, 5000)), 6'd0, 0);
        repeat (4) idle(0);
        repeat (12) step(1, 1, 34'($urandom_range(0, 5000)), 6'd2, 1);
        repeat (6) idle(1);

        // Reset with two buffered results and two tags in flight.
        step(1, 1, 34'sd11, 6'd0, 0);
        step(1, 1, 34'sd22, 6'd0, 0);
        repeat (3) idle(0);
        step(1, 0, 34'sd33, 6'd0, 0);
        step(1, 1, 34'sd44, 6'd0, 0);
        do_reset();
        repeat (6) idle(1);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            logic signed [33:0] p;
            p = ($urandom_range(0, 3) == 0) ? 34'({$urandom(), $urandom()})
                                            : 34'(int'($urandom_range(0, 20000)) - 10000);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, p,
                 6'($urandom_range(0, 12)), $urandom_range(0, 3) != 0);
        end
        repeat (10) idle(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mac_result_collector.md
Name: mac_result_collector

Overview:
- Output-side companion of the SIMD MAC: consumes the MAC's un-flagged partial-sum output on the correct cycle and accumulates partial sums over a group.
- Requantises each group (round, shift, saturate) to OUT_WIDTH and buffers results in a small FIFO behind a valid/ready port.
- Issues credit to the operand feeder so the MAC is never fired when there is no result space.

Parameters:
- PSUM_WIDTH, 34, width of MAC out (2*16 + log2(4))
- MAC_LATENCY, 3, cycles from MAC input_valid sample to stable MAC out (pipeline depth + 1)
- ACC_WIDTH, 40, internal group accumulator width
- OUT_WIDTH, 16, requantised result width
- FIFO_DEPTH, 4, result FIFO entries (power of two, >= 2)

Ports:
- clk  in  1  clock
- rst_in  in  1  synchronous, active-high reset
- issue_valid_in  in  1  feeder fires the MAC this cycle (mirrors MAC input_valid)
- issue_last_in  in  1  this issue closes an accumulation group
- issue_ready_out  out  1  credit: an issue is accepted this cycle
- psum_in  in  PSUM_WIDTH  MAC out, two's complement
- cfg_shift_in  in  6  arithmetic right shift applied at group close; sampled on the close cycle
- res_valid_out  out  1  FIFO head valid
- res_ready_in  in  1  downstream accepts the head
- res_data_out  out  OUT_WIDTH  requantised result, signed
- res_sat_out  out  1  the head result was clamped
- busy_out  out  1  tags in flight, or the accumulator holds a partial group

Behaviour:
- Reset: on any rising clk edge with rst_in=1, clear the tag delay line, accumulator, FIFO pointers and counts.
  - res_valid_out=0, res_data_out=0, res_sat_out=0, busy_out=0.
  - issue_ready_out=1 from the first cycle after reset.
  - Reset mid-operation discards in-flight tags, the partial group and buffered results. psum_in is ignored until a new issue matures.
- Accepted issue = issue_valid_in & issue_ready_out. A non-accepted issue pushes nothing; the feeder must not fire the MAC that cycle.
- Tag delay line: MAC_LATENCY stages carrying {valid,last}, shifting every cycle. A tag that reaches the final stage is "mature"; psum_in is sampled in that same cycle.
- Mature, last=0: acc <= acc + sext(psum_in).
- Mature, last=1:
  - sum = acc + sext(psum_in).
  - r = (sum + (shift>0 ? 1<<(shift-1) : 0)) >>> shift, computed in ACC_WIDTH+1 bits.
  - Clamp r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and set sat=1 when clamped.
  - Push {r,sat} into the FIFO; acc <= 0.
  - A mature tag on the next cycle starts the new group from 0.
- Accumulator wrap: ACC_WIDTH overflow wraps silently. With the defaults this needs more than 64 max-magnitude psums; it is documented and not detected.
- Credit:
  - reserved = FIFO count + number of last=1 tags in the delay line.
  - issue_ready_out = (reserved < FIFO_DEPTH), combinational from registers only.
  - The FIFO therefore never overflows, and a push into a full FIFO is impossible by construction.
- FIFO: first-word fall-through.
  - res_valid_out = count != 0; res_data_out/res_sat_out show the head and hold while res_valid_out & !res_ready_in.
  - Pop on res_valid_out & res_ready_in.
  - Simultaneous push and pop: count unchanged, both take effect.
  - Pop when empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH.
  - res_data_out = 0 when empty.
- Latency: a last issue accepted at cycle t matures at t+MAC_LATENCY. res_valid_out rises at t+MAC_LATENCY+1 if the FIFO was empty.
- busy_out = any delay-line valid | acc_nonempty flag. The flag is set by a mature last=0 tag and cleared by a last=1 tag.

Decomposition:
- Package mac_pkg: default PSUM_WIDTH, ACC_WIDTH, OUT_WIDTH, MAC_LATENCY constants; typedef res_entry_t {logic signed [OUT_WIDTH-1:0] data; logic sat;}; typedef tag_t {logic valid; logic last;}.
- One sub-module: mac_result_fifo (sync FWFT FIFO of res_entry_t, depth FIFO_DEPTH, exposes count). The delay line, accumulator and requantiser stay in the top.

Test Plan:
- Single group of 1 issue (last=1), psum=0x000001234 at maturity, shift=4 -> res_data_out=0x0123 at t+4, sat=0; res_valid_out low before t+4.
- 4-issue group, psums 100, -30, 7, 3, shift=0 -> exactly one result 80, busy_out high from issue until the result is pushed, then 0.
- Saturation: psum=+2^30, shift=0 -> res_data_out=0x7FFF, sat=1; psum=-2^30 -> 0x8000, sat=1; shift=1 with psum=3 -> 2 (round half up).
- Backpressure: res_ready_in=0, issue 6 consecutive last=1 -> issue_ready_out drops after 4 accepted, FIFO holds 4 in order. Raise res_ready_in -> drains in order, credit returns one cycle per pop, no loss.
- Simultaneous push/pop with FIFO at FIFO_DEPTH-1 and ready=1 -> count constant, order preserved across pointer wrap (8+ results).
- Reset asserted for 1 cycle with 2 tags in flight and a 2-entry FIFO -> all outputs 0 next cycle. The stale psum at the old maturity cycle produces no result.
